// File: rtl/light_conflict_monitor.sv
// Traffic signal conflict monitor: passes lamp commands to the field,
// detects conflicting, invalid or badly sequenced commands and forces flash.
module light_conflict_monitor #(
    parameter int PERSIST_CYCLES = 4,
    parameter int MIN_YELLOW     = 3,
    parameter int STARTUP_CYCLES = 16,
    parameter int FLASH_HALF     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] NS1_light,
    input  logic [3:0] NS2_light,
    input  logic [3:0] EW1_light,
    input  logic [3:0] EW2_light,
    input  logic       fault_clear,
    output logic [3:0] NS1_out,
    output logic [3:0] NS2_out,
    output logic [3:0] EW1_out,
    output logic [3:0] EW2_out,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] trip_count
);

    localparam int PW = $clog2(PERSIST_CYCLES + 1);
    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam int SW = $clog2(STARTUP_CYCLES + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);

    localparam logic [3:0] RED    = 4'b0001;
    localparam logic [3:0] YELLOW = 4'b0010;
    localparam logic [3:0] DARK   = 4'b0000;

    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        MONITOR = 2'd1,
        FLASH   = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] start_cnt;
    logic [PW-1:0] conf_cnt;
    logic [PW-1:0] inv_cnt;
    logic [PW-1:0] conf_nxt;
    logic [PW-1:0] inv_nxt;
    logic [FW-1:0] flash_cnt;
    logic          flash_on;

    // Lanes 0/1 are north-south, lanes 2/3 are east-west
    logic [3:0]    lamp [4];
    logic [3:0]    prev [4];
    logic [YW-1:0] ycnt [4];

    logic [3:0]  go;
    logic [3:0]  bad;
    logic [3:0]  skip;
    logic [3:0]  short_y;
    logic        conflict;
    logic        invalid;
    logic        conf_trip;
    logic        inv_trip;
    logic        trip;
    logic [2:0]  code_nxt;
    logic        half_done;
    logic [15:0] drive;

    assign lamp[0] = NS1_light;
    assign lamp[1] = NS2_light;
    assign lamp[2] = EW1_light;
    assign lamp[3] = EW2_light;

    // Per-lane decode of the current sample against that lane's history
    always_comb begin
        go      = '0;
        bad     = '0;
        skip    = '0;
        short_y = '0;
        for (int i = 0; i < 4; i++) begin
            go[i]      = lamp[i][2] | lamp[i][3];
            bad[i]     = (lamp[i] == 4'b0000) ||
                         ((lamp[i] & (lamp[i] - 4'd1)) != 4'b0000);
            skip[i]    = (prev[i][2] | prev[i][3]) && (lamp[i] == RED);
            short_y[i] = (prev[i] == YELLOW) && (lamp[i] == RED) &&
                         (ycnt[i] < YW'(MIN_YELLOW));
        end
    end

    // Persistence of static faults and lowest-code-wins trip selection
    always_comb begin
        conflict = (go[0] | go[1]) & (go[2] | go[3]);
        invalid  = |bad;
        conf_nxt = '0;
        inv_nxt  = '0;
        if (conflict)
            conf_nxt = (conf_cnt == PW'(PERSIST_CYCLES)) ?
                       conf_cnt : conf_cnt + 1'b1;
        if (invalid)
            inv_nxt = (inv_cnt == PW'(PERSIST_CYCLES)) ?
                      inv_cnt : inv_cnt + 1'b1;
        conf_trip = (conf_nxt == PW'(PERSIST_CYCLES));
        inv_trip  = (inv_nxt == PW'(PERSIST_CYCLES));
        trip      = conf_trip | inv_trip | (|skip) | (|short_y);
        code_nxt  = 3'd0;
        if (conf_trip)
            code_nxt = 3'd1;
        else if (inv_trip)
            code_nxt = 3'd2;
        else if (|skip)
            code_nxt = 3'd3;
        else if (|short_y)
            code_nxt = 3'd4;
    end

    // Next value of the four field lamp drives
    always_comb begin
        half_done = (flash_cnt == FW'(FLASH_HALF - 1));
        drive     = {RED, RED, RED, RED};
        unique case (state)
            MONITOR: begin
                if (!trip)
                    drive = {NS1_light, NS2_light, EW1_light, EW2_light};
            end
            FLASH: begin
                if (!fault_clear) begin
                    if (flash_on ^ half_done)
                        drive = {RED, RED, RED, RED};
                    else
                        drive = {DARK, DARK, DARK, DARK};
                end
            end
            default: drive = {RED, RED, RED, RED};
        endcase
    end

    // Lamp history runs in every state so checks are primed on MONITOR entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                prev[i] <= RED;
                ycnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                prev[i] <= lamp[i];
                if (lamp[i] != YELLOW)
                    ycnt[i] <= '0;
                else if (ycnt[i] != YW'(MIN_YELLOW))
                    ycnt[i] <= ycnt[i] + 1'b1;
            end
        end
    end

    // Monitor FSM with registered lamp drives and fault reporting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= STARTUP;
            start_cnt  <= '0;
            conf_cnt   <= '0;
            inv_cnt    <= '0;
            flash_cnt  <= '0;
            flash_on   <= 1'b1;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            trip_count <= 8'd0;
            {NS1_out, NS2_out, EW1_out, EW2_out} <= {RED, RED, RED, RED};
        end else begin
            {NS1_out, NS2_out, EW1_out, EW2_out} <= drive;
            unique case (state)
                STARTUP: begin
                    conf_cnt <= '0;
                    inv_cnt  <= '0;
                    if (start_cnt == SW'(STARTUP_CYCLES - 1)) begin
                        state     <= MONITOR;
                        start_cnt <= '0;
                    end else begin
                        start_cnt <= start_cnt + 1'b1;
                    end
                end
                MONITOR: begin
                    if (trip) begin
                        state      <= FLASH;
                        fault      <= 1'b1;
                        fault_code <= code_nxt;
                        flash_on   <= 1'b1;
                        flash_cnt  <= '0;
                        conf_cnt   <= '0;
                        inv_cnt    <= '0;
                        if (trip_count != 8'hFF)
                            trip_count <= trip_count + 8'd1;
                    end else begin
                        conf_cnt <= conf_nxt;
                        inv_cnt  <= inv_nxt;
                    end
                end
                FLASH: begin
                    if (fault_clear) begin
                        state      <= STARTUP;
                        fault      <= 1'b0;
                        fault_code <= 3'd0;
                        start_cnt  <= '0;
                        conf_cnt   <= '0;
                        inv_cnt    <= '0;
                        flash_cnt  <= '0;
                        flash_on   <= 1'b1;
                    end else if (half_done) begin
                        flash_cnt <= '0;
                        flash_on  <= ~flash_on;
                    end else begin
                        flash_cnt <= flash_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STARTUP;
                    fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Directed bench for light_conflict_monitor: vector table for pass-through,
// hand sequences for persistence, sequencing faults, flash, clear and reset.
module tb_light_conflict_monitor;

    localparam logic [3:0] R = 4'b0001;
    localparam logic [3:0] Y = 4'b0010;
    localparam logic [3:0] G = 4'b0100;
    localparam logic [3:0] A = 4'b1000;
    localparam logic [15:0] ALL_RED  = 16'h1111;
    localparam logic [15:0] ALL_DARK = 16'h0000;

    logic       clk;
    logic       rst;
    logic [3:0] NS1_light;
    logic [3:0] NS2_light;
    logic [3:0] EW1_light;
    logic [3:0] EW2_light;
    logic       fault_clear;
    logic [3:0] NS1_out;
    logic [3:0] NS2_out;
    logic [3:0] EW1_out;
    logic [3:0] EW2_out;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] trip_count;

    int tests;
    int fails;

    typedef struct packed {
        logic [15:0] lights;
        logic        clr;
        logic [15:0] exp_out;
        logic        exp_fault;
    } vec_t;

    vec_t vec [25];

    light_conflict_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .NS1_light  (NS1_light),
        .NS2_light  (NS2_light),
        .EW1_light  (EW1_light),
        .EW2_light  (EW2_light),
        .fault_clear(fault_clear),
        .NS1_out    (NS1_out),
        .NS2_out    (NS2_out),
        .EW1_out    (EW1_out),
        .EW2_out    (EW2_out),
        .fault      (fault),
        .fault_code (fault_code),
        .trip_count (trip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] outs();
        return {NS1_out, NS2_out, EW1_out, EW2_out};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [15:0] l);
        {NS1_light, NS2_light, EW1_light, EW2_light} = l;
    endtask

    // Expects the next 16 edges all-red, then pass-through of exp_pass
    task automatic check_startup(input string name, input logic [15:0] exp_pass);
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("%s_red%0d", name, i), {outs(), fault},
                {ALL_RED, 1'b0});
        end
        step();
        chk($sformatf("%s_pass", name), {outs(), fault}, {exp_pass, 1'b0});
    endtask

    task automatic clear_pulse();
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
    endtask

    int exp_trip;

    initial begin
        tests = 0;
        fails = 0;

        vec[0]  = '{{G, G, R, R}, 1'b0, {G, G, R, R}, 1'b0};
        vec[1]  = '{{Y, Y, R, R}, 1'b0, {Y, Y, R, R}, 1'b0};
        vec[2]  = '{{Y, Y, R, R}, 1'b1, {Y, Y, R, R}, 1'b0};
        vec[3]  = '{{Y, Y, R, R}, 1'b0, {Y, Y, R, R}, 1'b0};
        vec[4]  = '{{R, R, R, R}, 1'b0, {R, R, R, R}, 1'b0};
        vec[5]  = '{{R, R, A, G}, 1'b0, {R, R, A, G}, 1'b0};
        vec[6]  = '{{R, R, Y, Y}, 1'b0, {R, R, Y, Y}, 1'b0};
        vec[7]  = '{{R, R, Y, Y}, 1'b1, {R, R, Y, Y}, 1'b0};
        vec[8]  = '{{R, R, Y, Y}, 1'b0, {R, R, Y, Y}, 1'b0};
        vec[9]  = '{{R, R, R, R}, 1'b0, {R, R, R, R}, 1'b0};
        vec[10] = '{{G, R, R, R}, 1'b0, {G, R, R, R}, 1'b0};
        vec[11] = '{{G, R, G, R}, 1'b0, {G, R, G, R}, 1'b0};
        vec[12] = '{{G, R, G, R}, 1'b0, {G, R, G, R}, 1'b0};
        vec[13] = '{{G, R, G, R}, 1'b0, {G, R, G, R}, 1'b0};
        vec[14] = '{{G, R, Y, R}, 1'b0, {G, R, Y, R}, 1'b0};
        vec[15] = '{{G, R, Y, R}, 1'b0, {G, R, Y, R}, 1'b0};
        vec[16] = '{{G, R, Y, R}, 1'b0, {G, R, Y, R}, 1'b0};
        vec[17] = '{{G, R, R, R}, 1'b0, {G, R, R, R}, 1'b0};
        vec[18] = '{{G, R, G, R}, 1'b0, {G, R, G, R}, 1'b0};
        vec[19] = '{{G, R, G, R}, 1'b0, {G, R, G, R}, 1'b0};
        vec[20] = '{{G, R, G, R}, 1'b0, {G, R, G, R}, 1'b0};
        vec[21] = '{{G, R, Y, R}, 1'b0, {G, R, Y, R}, 1'b0};
        vec[22] = '{{G, R, Y, R}, 1'b0, {G, R, Y, R}, 1'b0};
        vec[23] = '{{G, R, Y, R}, 1'b0, {G, R, Y, R}, 1'b0};
        vec[24] = '{{G, R, R, R}, 1'b0, {G, R, R, R}, 1'b0};

        // Reset and startup hold with NS1 green
        rst = 1'b1;
        fault_clear = 1'b0;
        set_lanes({G, R, R, R});
        step();
        step();
        chk("reset_state", {outs(), fault, fault_code, trip_count},
            {ALL_RED, 1'b0, 3'd0, 8'd0});
        rst = 1'b0;
        check_startup("boot", {G, R, R, R});

        // Pass-through table, including short conflicts and ignored clears
        for (int i = 0; i < 25; i++) begin
            set_lanes(vec[i].lights);
            fault_clear = vec[i].clr;
            step();
            chk($sformatf("vec%0d", i), {outs(), fault},
                {vec[i].exp_out, vec[i].exp_fault});
        end
        fault_clear = 1'b0;

        // Conflict persisting four samples trips with code 1
        set_lanes({G, R, G, R});
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("conf_wait%0d", i), {fault, fault_code},
                {1'b0, 3'd0});
        end
        step();
        chk("conf_trip", {outs(), fault, fault_code, trip_count},
            {ALL_RED, 1'b1, 3'd1, 8'd1});

        // Flash cadence; a new invalid lane must not disturb the record
        set_lanes({G, 4'b0000, G, R});
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("flash%0d", k), {outs(), fault},
                {((k / 8) % 2 == 0) ? ALL_RED : ALL_DARK, 1'b1});
        end
        chk("flash_keep", {fault_code, trip_count}, {3'd1, 8'd1});

        // Operator clear restarts the startup hold, count retained
        set_lanes({R, R, R, G});
        clear_pulse();
        chk("clear", {outs(), fault, fault_code, trip_count},
            {ALL_RED, 1'b0, 3'd0, 8'd1});
        check_startup("clr1", {R, R, R, G});

        // Green straight to red
        set_lanes({R, R, R, R});
        step();
        chk("skip_y", {fault, fault_code, trip_count}, {1'b1, 3'd3, 8'd2});

        // Two yellow samples then red
        clear_pulse();
        check_startup("clr2", {R, R, R, R});
        set_lanes({R, R, R, Y});
        step();
        step();
        chk("short_y_wait", {fault, fault_code}, {1'b0, 3'd0});
        set_lanes({R, R, R, R});
        step();
        chk("short_y", {fault, fault_code, trip_count}, {1'b1, 3'd4, 8'd3});

        // Three yellow samples then red is legal
        set_lanes({R, R, R, G});
        clear_pulse();
        check_startup("clr3", {R, R, R, G});
        set_lanes({R, R, R, Y});
        step();
        step();
        step();
        set_lanes({R, R, R, R});
        step();
        chk("full_y", {outs(), fault, fault_code, trip_count},
            {ALL_RED, 1'b0, 3'd0, 8'd3});

        // Conflict and invalid persisting together: code 1 wins
        set_lanes({G, 4'b0110, G, R});
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("prio_wait%0d", i), fault, 1'b0);
        end
        step();
        chk("prio", {fault, fault_code, trip_count}, {1'b1, 3'd1, 8'd4});

        // Repeated skipped-yellow trips drive the count into saturation
        exp_trip = 4;
        for (int n = 0; n < 256; n++) begin
            set_lanes({R, R, R, G});
            clear_pulse();
            repeat (16) step();
            set_lanes({R, R, R, R});
            step();
            exp_trip = (exp_trip < 255) ? exp_trip + 1 : 255;
            chk($sformatf("sat%0d", n), {fault, trip_count},
                {1'b1, exp_trip[7:0]});
        end

        // Asynchronous reset mid-flash
        set_lanes({G, R, R, R});
        rst = 1'b1;
        #1;
        chk("rst_flash", {outs(), fault, fault_code, trip_count},
            {ALL_RED, 1'b0, 3'd0, 8'd0});
        step();
        rst = 1'b0;
        check_startup("rst1", {G, R, R, R});

        // Reset mid-startup restarts the full hold
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_startup("rst2", {G, R, R, R});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
